// File: rtl/systolic_array_pkg.sv
// Shared definitions for the systolic MAC array.
//   - Default array dimension and element/partial-sum widths.
//   - Preload sequencer state type.
//   - Lane-slicing helpers: lane k of a flat bus of W-bit lanes occupies
//     bits [k*W +: W].
package systolic_array_pkg;

  localparam int DEF_PE_SIZE    = 2;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_PSUM_WIDTH = 32;

  typedef enum logic {
    PL_IDLE = 1'b0,
    PL_LOAD = 1'b1
  } preload_state_e;

  // Low bit index of a lane within a flat multi-lane bus.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

  // Width of a counter that indexes n rows; never narrower than one bit.
  function automatic int ctr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_array_pe.sv
// Single processing element of the systolic array.
//   Holds one stationary ifmap value, one weight register fed from above and
//   one partial-sum register fed from the left. The MAC adds ifmap*weight
//   (using the weight held before the edge) to the incoming psum.
// Ports:
//   clk, rst_n      clock and synchronous active-high reset
//   ifmap_we_i      write strobe for the stationary ifmap value
//   ifmap_i         ifmap value to store
//   w_i / w_en_i    weight and weight-valid from the PE above
//   p_i / p_en_i    psum and psum-valid from the PE to the left
//   ifmap_o         stored ifmap value
//   w_o / w_en_o    registered weight and valid, towards the PE below
//   p_o / p_en_o    registered psum and valid, towards the PE to the right
module systolic_pe
  import systolic_array_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PSUM_WIDTH = DEF_PSUM_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ifmap_we_i,
  input  logic [DATA_WIDTH-1:0] ifmap_i,
  input  logic [DATA_WIDTH-1:0] w_i,
  input  logic                  w_en_i,
  input  logic [PSUM_WIDTH-1:0] p_i,
  input  logic                  p_en_i,
  output logic [DATA_WIDTH-1:0] ifmap_o,
  output logic [DATA_WIDTH-1:0] w_o,
  output logic                  w_en_o,
  output logic [PSUM_WIDTH-1:0] p_o,
  output logic                  p_en_o
);

  logic [DATA_WIDTH-1:0]   ifmap_q, ifmap_d;
  logic [DATA_WIDTH-1:0]   w_q, w_d;
  logic                    w_en_q, w_en_d;
  logic [PSUM_WIDTH-1:0]   p_q, p_d;
  logic                    p_en_q, p_en_d;
  logic [2*DATA_WIDTH-1:0] prod;
  logic [PSUM_WIDTH-1:0]   mac_sum;

  // Unsigned product, zero-extended; the add wraps modulo 2^PSUM_WIDTH.
  assign prod    = ifmap_q * w_q;
  assign mac_sum = p_i + PSUM_WIDTH'(prod);

  always_comb begin
    ifmap_d = ifmap_we_i ? ifmap_i : ifmap_q;
    w_en_d  = w_en_i;
    w_d     = w_en_i ? w_i : w_q;
    p_en_d  = p_en_i;
    p_d     = p_en_i ? mac_sum : p_q;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      ifmap_q <= '0;
      w_q     <= '0;
      w_en_q  <= 1'b0;
      p_q     <= '0;
      p_en_q  <= 1'b0;
    end else begin
      ifmap_q <= ifmap_d;
      w_q     <= w_d;
      w_en_q  <= w_en_d;
      p_q     <= p_d;
      p_en_q  <= p_en_d;
    end
  end

  assign ifmap_o = ifmap_q;
  assign w_o     = w_q;
  assign w_en_o  = w_en_q;
  assign p_o     = p_q;
  assign p_en_o  = p_en_q;

endmodule

// File: rtl/systolic_array.sv
// PE_SIZE x PE_SIZE weight-streaming, ifmap-stationary systolic MAC array.
//   Weights flow top to bottom down each column, partial sums flow left to
//   right along each row. A preload sequencer writes one ifmap row per cycle
//   (row 0 on the start pulse, rows 1..N-1 on the following cycles).
// Ports:
//   clk, rst_n        clock and synchronous active-high reset
//   ifmap_row_i       ifmap row being preloaded, lane c = column c
//   weight_col_i      weights entering the top of each column
//   psum_row_i        psums entering the left of each row
//   ifmap_preload_i   start pulse for the row-by-row preload
//   weight_en_col_i   per-column weight valid
//   psum_en_row_i     per-row psum valid
//   ifmap_row_o       stored ifmap of the bottom row
//   weight_col_o      weight registers of the bottom row
//   psum_row_o        psum registers of the last column
//   weight_en_col_o   weight-valid registers of the bottom row
//   psum_en_row_o     psum-valid registers of the last column
module systolic_array
  import systolic_array_pkg::*;
#(
  parameter int PE_SIZE    = DEF_PE_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PSUM_WIDTH = DEF_PSUM_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [PE_SIZE*DATA_WIDTH-1:0]    ifmap_row_i,
  input  logic [PE_SIZE*DATA_WIDTH-1:0]    weight_col_i,
  input  logic [PE_SIZE*PSUM_WIDTH-1:0]    psum_row_i,
  input  logic                             ifmap_preload_i,
  input  logic [PE_SIZE-1:0]               weight_en_col_i,
  input  logic [PE_SIZE-1:0]               psum_en_row_i,
  output logic [PE_SIZE*DATA_WIDTH-1:0]    ifmap_row_o,
  output logic [PE_SIZE*DATA_WIDTH-1:0]    weight_col_o,
  output logic [PE_SIZE*PSUM_WIDTH-1:0]    psum_row_o,
  output logic [PE_SIZE-1:0]               weight_en_col_o,
  output logic [PE_SIZE-1:0]               psum_en_row_o
);

  localparam int N  = PE_SIZE;
  localparam int RW = ctr_width(PE_SIZE);

  // ---------------------------------------------------------------------
  // Preload sequencer
  // ---------------------------------------------------------------------
  preload_state_e   state_q, state_d;
  logic [RW-1:0]    row_q, row_d;
  logic [N-1:0]     row_we;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= PL_IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  // A start pulse always wins: it writes row 0 and (re)starts the walk
  // through the remaining rows, even if a previous preload is mid-way.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    if (ifmap_preload_i) begin
      if (N > 1) begin
        state_d = PL_LOAD;
        row_d   = RW'(1);
      end else begin
        state_d = PL_IDLE;
        row_d   = '0;
      end
    end else if (state_q == PL_LOAD) begin
      if (row_q == RW'(N - 1)) begin
        state_d = PL_IDLE;
        row_d   = '0;
      end else begin
        row_d = row_q + RW'(1);
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row_we
    if (gi == 0) begin : g_first
      assign row_we[gi] = ifmap_preload_i ||
                          (state_q == PL_LOAD && row_q == RW'(gi));
    end else begin : g_rest
      assign row_we[gi] = !ifmap_preload_i &&
                          (state_q == PL_LOAD && row_q == RW'(gi));
    end
  end

  // ---------------------------------------------------------------------
  // PE interconnect: w_net[r][c] feeds PE(r,c) from above, w_net[r+1][c]
  // leaves it downward; p_net[r][c] feeds PE(r,c) from the left.
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] w_net   [0:N][0:N-1];
  logic                  wen_net [0:N][0:N-1];
  logic [PSUM_WIDTH-1:0] p_net   [0:N-1][0:N];
  logic                  pen_net [0:N-1][0:N];

  for (genvar gi = 0; gi < N; gi++) begin : g_edges
    localparam int DLO = lane_lo(gi, DATA_WIDTH);
    localparam int PLO = lane_lo(gi, PSUM_WIDTH);

    assign w_net[0][gi]   = weight_col_i[DLO +: DATA_WIDTH];
    assign wen_net[0][gi] = weight_en_col_i[gi];
    assign p_net[gi][0]   = psum_row_i[PLO +: PSUM_WIDTH];
    assign pen_net[gi][0] = psum_en_row_i[gi];

    assign weight_col_o[DLO +: DATA_WIDTH] = w_net[N][gi];
    assign weight_en_col_o[gi]             = wen_net[N][gi];
    assign psum_row_o[PLO +: PSUM_WIDTH]   = p_net[gi][N];
    assign psum_en_row_o[gi]               = pen_net[gi][N];
  end

  for (genvar gi = 0; gi < N * N; gi++) begin : g_pe
    localparam int R   = gi / N;
    localparam int C   = gi % N;
    localparam int DLO = lane_lo(C, DATA_WIDTH);

    // Only the bottom row's stored ifmap is visible on the readback port.
    logic [DATA_WIDTH-1:0] ifmap_rb_maybe_unused;

    systolic_pe #(
      .DATA_WIDTH (DATA_WIDTH),
      .PSUM_WIDTH (PSUM_WIDTH)
    ) u_pe (
      .clk        (clk),
      .rst_n      (rst_n),
      .ifmap_we_i (row_we[R]),
      .ifmap_i    (ifmap_row_i[DLO +: DATA_WIDTH]),
      .w_i        (w_net[R][C]),
      .w_en_i     (wen_net[R][C]),
      .p_i        (p_net[R][C]),
      .p_en_i     (pen_net[R][C]),
      .ifmap_o    (ifmap_rb_maybe_unused),
      .w_o        (w_net[R+1][C]),
      .w_en_o     (wen_net[R+1][C]),
      .p_o        (p_net[R][C+1]),
      .p_en_o     (pen_net[R][C+1])
    );

    if (R == N - 1) begin : g_readback
      assign ifmap_row_o[DLO +: DATA_WIDTH] = ifmap_rb_maybe_unused;
    end
  end

endmodule

// File: tb/tb_systolic_array.sv
module tb_systolic_array;

  localparam int N    = 2;
  localparam int DW   = 8;
  localparam int PW   = 32;
  localparam int MAXE = 2000;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N*DW-1:0]     ifmap_row_i, weight_col_i;
  logic [N*PW-1:0]     psum_row_i;
  logic                ifmap_preload_i;
  logic [N-1:0]        weight_en_col_i, psum_en_row_i;
  logic [N*DW-1:0]     ifmap_row_o, weight_col_o;
  logic [N*PW-1:0]     psum_row_o;
  logic [N-1:0]        weight_en_col_o, psum_en_row_o;

  systolic_array #(.PE_SIZE(N), .DATA_WIDTH(DW), .PSUM_WIDTH(PW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ifmap_row_i     (ifmap_row_i),
    .weight_col_i    (weight_col_i),
    .psum_row_i      (psum_row_i),
    .ifmap_preload_i (ifmap_preload_i),
    .weight_en_col_i (weight_en_col_i),
    .psum_en_row_i   (psum_en_row_i),
    .ifmap_row_o     (ifmap_row_o),
    .weight_col_o    (weight_col_o),
    .psum_row_o      (psum_row_o),
    .weight_en_col_o (weight_en_col_o),
    .psum_en_row_o   (psum_en_row_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: input history per edge plus the ifmap matrix held
  // before each edge; outputs are derived from the closed-form latency rules.
  logic [N*DW-1:0] w_h   [MAXE];
  logic [N-1:0]    wen_h [MAXE];
  logic [N*PW-1:0] p_h   [MAXE];
  logic [N-1:0]    pen_h [MAXE];
  logic [DW-1:0]   ifm_h [MAXE][N][N];
  logic [DW-1:0]   mifm  [N][N];
  logic [PW-1:0]   exp_p [N];
  int edge_n   = 0;
  int last_rst = -1;
  int pl_left  = 0;
  int pl_row   = 0;

  // Last enabled weight for column c sampled at or before edge k, since reset.
  function automatic logic [DW-1:0] wlook(input int c, input int k);
    for (int j = k; j > last_rst && j >= 0; j--)
      if (wen_h[j][c]) return w_h[j][c*DW +: DW];
    return '0;
  endfunction

  task automatic step();
    int t, e;
    logic [PW-1:0]   acc;
    logic [N*DW-1:0] exp_w, exp_ifm;
    logic [N-1:0]    exp_wen, exp_pen;
    t = edge_n;
    if (t >= MAXE) begin
      $display("FAIL history: got edge %0d expected below %0d", t, MAXE);
      $fatal(1, "history exhausted");
    end
    w_h[t] = weight_col_i; wen_h[t] = weight_en_col_i;
    p_h[t] = psum_row_i;   pen_h[t] = psum_en_row_i;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) ifm_h[t][r][c] = mifm[r][c];
    // Preload rules: pulse writes row 0, then rows 1..N-1 follow.
    if (rst_n) begin
      for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) mifm[r][c] = '0;
      pl_left = 0;
    end else if (ifmap_preload_i) begin
      for (int c = 0; c < N; c++) mifm[0][c] = ifmap_row_i[c*DW +: DW];
      pl_row = 1; pl_left = N - 1;
    end else if (pl_left > 0) begin
      for (int c = 0; c < N; c++) mifm[pl_row][c] = ifmap_row_i[c*DW +: DW];
      pl_row++; pl_left--;
    end
    @(posedge clk); #1;
    edge_n++;
    if (rst_n) last_rst = t;
    e = t - N + 1;
    for (int c = 0; c < N; c++) begin
      exp_wen[c]         = (e > last_rst) ? wen_h[e][c] : 1'b0;
      exp_w[c*DW +: DW]  = wlook(c, e);
      exp_ifm[c*DW +: DW] = mifm[N-1][c];
    end
    for (int r = 0; r < N; r++) begin
      if (e > last_rst && pen_h[e][r]) begin
        acc = p_h[e][r*PW +: PW];
        for (int c = 0; c < N; c++)
          acc += PW'(ifm_h[e+c][r][c]) * PW'(wlook(c, e + c - r - 1));
        exp_p[r] = acc;
      end else if (t == last_rst) begin
        exp_p[r] = '0;
      end
      exp_pen[r] = (e > last_rst) ? pen_h[e][r] : 1'b0;
    end
    if (last_rst >= 0) begin
      check_eq("psum_r0",  psum_row_o[0 +: PW],  exp_p[0]);
      check_eq("psum_r1",  psum_row_o[PW +: PW], exp_p[1]);
      check_eq("psum_en",  psum_en_row_o,   exp_pen);
      check_eq("wcol",     weight_col_o,    exp_w);
      check_eq("wcol_en",  weight_en_col_o, exp_wen);
      check_eq("ifmap_rb", ifmap_row_o,     exp_ifm);
    end
    $display("edge %0d rst=%0b pre=%0b psum_o=%h pen_o=%b w_o=%h wen_o=%b ifm_o=%h",
             t, rst_n, ifmap_preload_i, psum_row_o, psum_en_row_o,
             weight_col_o, weight_en_col_o, ifmap_row_o);
  endtask

  task automatic drive_random();
    ifmap_row_i     = N*DW'($urandom);
    weight_col_i    = N*DW'($urandom);
    psum_row_i      = {$urandom, $urandom};
    weight_en_col_i = N'($urandom);
    psum_en_row_i   = N'($urandom);
    ifmap_preload_i = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) mifm[r][c] = '0;
    for (int r = 0; r < N; r++) exp_p[r] = '0;

    // Reset with random inputs, held two cycles.
    rst_n = 1'b1;
    drive_random(); step();
    drive_random(); step();
    check_eq("rst_psum", psum_row_o, '0);
    check_eq("rst_wcol", weight_col_o, '0);

    // Preload {4,2} / {3,1}, then steady MAC with weights c0=5, c1=7.
    rst_n = 1'b0;
    weight_col_i = 16'h0705; weight_en_col_i = 2'b11;
    psum_row_i = '0; psum_en_row_i = 2'b11;
    ifmap_preload_i = 1'b1; ifmap_row_i = 16'h0204; step();
    ifmap_preload_i = 1'b0; ifmap_row_i = 16'h0103; step();
    ifmap_row_i = 16'($urandom);
    repeat (6) step();
    check_eq("steady_r0", psum_row_o[0 +: PW], 34);
    check_eq("steady_r1", psum_row_o[PW +: PW], 22);
    check_eq("steady_ifm", ifmap_row_o, 16'h0103);

    // Psum bias visible exactly two cycles later.
    psum_row_i = {32'd1000, 32'd100};
    step(); step();
    check_eq("bias_r0", psum_row_o[0 +: PW], 134);
    check_eq("bias_r1", psum_row_o[PW +: PW], 1022);
    check_eq("bias_en", psum_en_row_o, 2'b11);

    // Weight gating: old weights hold, valid falls after two cycles.
    weight_en_col_i = 2'b00; weight_col_i = 16'h1111;
    step(); step();
    check_eq("gate_wcol", weight_col_o, 16'h0705);
    check_eq("gate_wen", weight_en_col_o, 2'b00);
    check_eq("gate_r0", psum_row_o[0 +: PW], 134);

    // Psum hold.
    psum_en_row_i = 2'b00; psum_row_i = {$urandom, $urandom};
    step(); step();
    check_eq("hold_en", psum_en_row_o, 2'b00);
    check_eq("hold_r1", psum_row_o[PW +: PW], 1022);

    // Wrap-around: 0xFFFFFFFF + 2*0xFE01 mod 2^32.
    rst_n = 1'b1; step();
    rst_n = 1'b0;
    weight_col_i = 16'hFFFF; weight_en_col_i = 2'b11;
    psum_row_i = {N{32'hFFFF_FFFF}}; psum_en_row_i = 2'b11;
    ifmap_preload_i = 1'b1; ifmap_row_i = 16'hFFFF; step();
    ifmap_preload_i = 1'b0; step();
    repeat (6) step();
    check_eq("wrap_r0", psum_row_o[0 +: PW], 32'h0001_FC01);
    check_eq("wrap_r1", psum_row_o[PW +: PW], 32'h0001_FC01);

    // Random traffic with occasional preloads and resets.
    for (int i = 0; i < 300; i++) begin
      drive_random();
      rst_n = ($urandom_range(0, 60) == 0);
      step();
    end

    // Reset in the middle of a preload aborts it.
    rst_n = 1'b0; weight_en_col_i = '0; psum_en_row_i = '0;
    ifmap_preload_i = 1'b1; ifmap_row_i = 16'hABCD; step();
    ifmap_preload_i = 1'b0; rst_n = 1'b1; step();
    rst_n = 1'b0; ifmap_row_i = 16'h5A5A; step(); step();
    check_eq("abort_ifm", ifmap_row_o, '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/systolic_array.md
Name: systolic_array

Overview:
- PE_SIZE x PE_SIZE systolic MAC array: the matrix-multiply core of the TPU MMU.
- Input-feature-map (ifmap) values are preloaded and held stationary, one per PE.
- Weights stream top-to-bottom down each column.
- Partial sums stream left-to-right along each row; each PE adds ifmap*weight to the passing psum.

Parameters:
- PE_SIZE, 2, array dimension N (rows = columns = N); legal range 1..16.
- DATA_WIDTH, 8, width of ifmap and weight elements.
- PSUM_WIDTH, 32, width of partial sums.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset; synchronous, active-high (rst_n=1 at a rising edge clears all state).
- ifmap_row_i  in  DATA_WIDTH*N  one ifmap row during preload; lane c = bits [c*DW +: DW] = column c.
- weight_col_i  in  DATA_WIDTH*N  weight entering top of column c (lane c).
- psum_row_i  in  PSUM_WIDTH*N  psum entering left of row r (lane r).
- ifmap_preload_i  in  1  one-cycle start pulse for the preload sequence.
- weight_en_col_i  in  N  per-column weight valid.
- psum_en_row_i  in  N  per-row psum valid.
- ifmap_row_o  out  DATA_WIDTH*N  stored ifmap of row N-1 (readback).
- weight_col_o  out  DATA_WIDTH*N  weight register of bottom-row PE, lane c.
- psum_row_o  out  PSUM_WIDTH*N  psum register of last-column PE, lane r.
- weight_en_col_o  out  N  weight-valid register of bottom-row PEs.
- psum_en_row_o  out  N  psum-valid register of last-column PEs.

Behaviour:
- Reset:
  - Every PE register clears to 0: ifmap, weight, weight_en, psum, psum_en.
  - Preload counter clears to idle.
  - All outputs are therefore 0.
  - Reset mid-preload aborts the preload.
- Preload:
  - At the edge where ifmap_preload_i=1, ifmap_row_i is written into row 0.
  - Over the following N-1 edges, ifmap_row_i is written into rows 1..N-1 in order, regardless of ifmap_preload_i.
  - The counter then returns to idle.
  - A pulse arriving during an active preload restarts the sequence at row 0.
  - Stored ifmap values hold until the next preload or reset.
- Weight flow, per PE(r,c), per edge:
  - en_q <= en_in.
  - If en_in=1: w_q <= w_in; otherwise w_q holds.
  - Row 0 takes its inputs from weight_col_i[c] / weight_en_col_i[c].
  - Row r>0 takes its inputs from PE(r-1,c).
- Psum flow, per PE(r,c), per edge:
  - pen_q <= pen_in.
  - If pen_in=1: p_q <= p_in + ifmap_rc * w_q; otherwise p_q holds.
  - Column 0 takes its inputs from psum_row_i[r] / psum_en_row_i[r].
  - Column c>0 takes its inputs from PE(r,c-1).
  - The MAC uses the PE's current w_q (the value before this edge), whether or not that weight is valid.
- Arithmetic:
  - Multiply is unsigned DATA_WIDTH x DATA_WIDTH, zero-extended to PSUM_WIDTH.
  - Add is modulo 2^PSUM_WIDTH (wraps, no saturation).
- Timing:
  - Weight latency: column c enters PE(r,c) after r+1 edges; weight_col_o has N cycles of latency.
  - Psum latency: N cycles.
  - If psum_row_i[r] is sampled valid at edge e, then after edge e+N-1: psum_row_o[r] = psum_row_i[r]@e + Σ_c ifmap[r][c]·W_c@(e+c-r-1), where W_c@k is the last enabled weight_col_i[c] sampled at or before edge k. psum_en_row_o[r]=1 at the same time.
- Concurrency: preload may overlap streaming. The MAC uses the ifmap value held before the edge.

Decomposition:
- Shared package holds the default widths (DATA_WIDTH, PSUM_WIDTH, PE_SIZE) and the lane-slicing helper functions.
- One sub-module, systolic_pe: a single PE with ifmap, weight and psum registers and the MAC.
- Top level generates N x N instances, the preload counter and the row write-enable decode.

Test Plan:
- Reset: drive random inputs with rst_n=1 -> all outputs 0 on the next edge; hold 2 cycles.
- Preload + steady MAC, N=2:
  - Pulse with ifmap_row_i=0x0204, then next cycle 0x0103; row0={4,2}, row1={3,1}.
  - Hold weight_col_i=0x0705 (c0=5, c1=7), all enables 1, psum_row_i=0.
  - Required steady state: psum_row_o row0=34, row1=22; ifmap_row_o=0x0103.
- Psum bias:
  - Same as the previous test but psum_row_i row0=100, row1=1000.
  - Required: 134 and 1022 exactly N=2 cycles after the bias is applied; psum_en_row_o=2'b11.
- Weight gating:
  - Load weights, then drop weight_en_col_i to 0 and change weight_col_i.
  - Required: weight_col_o holds the old values; weight_en_col_o falls 2 cycles later; psums are unchanged.
- Psum hold: psum_en_row_i=0 -> psum_row_o holds its last value; psum_en_row_o goes to 0 after 2 cycles.
- Overflow and reset:
  - With ifmap=0xFF, weight=0xFF and psum_row_i=0xFFFF_FFFF, the result wraps modulo 2^32.
  - Assert reset mid-preload -> all stored ifmap values read back as 0.
